// File: rtl/mulacc_simd_cfu_li2.sv
// SIMD multiply-accumulate CFU with handshaked request/response,
// several accumulators selected by function ID, and error responses.
module mulacc_simd_cfu_li2 #(
    parameter int CFU_FUNC_ID_W    = 5,
    parameter int CFU_REQ_DATA_W   = 32,
    parameter int CFU_REQ_ELT_W    = 8,
    parameter int CFU_RESP_DATA_W  = 32,
    parameter int CFU_ERR_ID_W     = 32,
    parameter int CFU_RESP_LATENCY = 3,
    parameter int N_ACC            = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data0,
    input  logic [CFU_REQ_DATA_W-1:0]  req_data1,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [CFU_RESP_DATA_W-1:0] resp_data,
    output logic                       resp_err,
    output logic [CFU_ERR_ID_W-1:0]    resp_err_id
);

    localparam int NE = CFU_REQ_DATA_W / CFU_REQ_ELT_W;
    localparam int EW = CFU_REQ_ELT_W;
    localparam int PW = 2 * CFU_REQ_ELT_W;
    localparam int RW = CFU_RESP_DATA_W;
    localparam int IW = CFU_FUNC_ID_W - 3;
    localparam int NS = CFU_RESP_LATENCY - 1;
    localparam int LS = NS - 1;

    localparam logic [1:0] OP_CLR  = 2'd0;
    localparam logic [1:0] OP_UMAC = 2'd1;
    localparam logic [1:0] OP_SMAC = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;

    logic          ready_q;
    logic          stall;

    logic [2:0]    in_op;
    logic [IW-1:0] in_idx;
    logic [1:0]    in_eid;
    logic [PW-1:0] in_prod [NE];

    logic [NS-1:0] st_vld;
    logic [PW-1:0] st_prod [NS][NE];
    logic [1:0]    st_op   [NS];
    logic [IW-1:0] st_idx  [NS];
    logic [1:0]    st_eid  [NS];

    logic [RW-1:0] acc [N_ACC];
    logic [RW-1:0] sum;
    logic [RW-1:0] cur;
    logic [RW-1:0] nxt;
    logic          upd_ok;

    logic          out_vld;
    logic          out_err;
    logic [1:0]    out_eid;
    logic [RW-1:0] out_data;

    assign stall      = out_vld & ~resp_ready;
    assign req_ready  = ready_q & ~stall;
    assign in_op      = req_func_id[2:0];
    assign in_idx     = req_func_id[CFU_FUNC_ID_W-1:3];
    assign resp_valid = out_vld;
    assign resp_data  = out_data;
    assign resp_err   = out_err;
    assign resp_err_id = {{(CFU_ERR_ID_W-2){1'b0}}, out_eid};

    // Classify the request and form per-element products at the input.
    always_comb begin
        logic [EW-1:0] a;
        logic [EW-1:0] b;
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        in_eid = 2'd0;
        if (in_op[2]) begin
            in_eid = 2'd1;
        end else if (int'(in_idx) >= N_ACC) begin
            in_eid = 2'd2;
        end
        for (int i = 0; i < NE; i++) begin
            a = req_data0[i*EW +: EW];
            b = req_data1[i*EW +: EW];
            if (in_op[1:0] == OP_SMAC) begin
                ax = {{EW{a[EW-1]}}, a};
                bx = {{EW{b[EW-1]}}, b};
            end else begin
                ax = {{EW{1'b0}}, a};
                bx = {{EW{1'b0}}, b};
            end
            in_prod[i] = ax * bx;
        end
    end

    // Valid bits of the delay stages; they freeze while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld <= '0;
        end else if (!stall) begin
            st_vld <= {st_vld[NS-2:0], req_valid & req_ready};
        end
    end

    // Payload of the delay stages; only meaningful alongside a valid bit.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < NE; i++) begin
                st_prod[0][i] <= in_prod[i];
            end
            st_op[0]  <= in_op[1:0];
            st_idx[0] <= in_idx;
            st_eid[0] <= in_eid;
            for (int s = 1; s < NS; s++) begin
                for (int i = 0; i < NE; i++) begin
                    st_prod[s][i] <= st_prod[s-1][i];
                end
                st_op[s]  <= st_op[s-1];
                st_idx[s] <= st_idx[s-1];
                st_eid[s] <= st_eid[s-1];
            end
        end
    end

    // Reduce the last stage's products and compute the new accumulator value.
    always_comb begin
        logic [PW-1:0] p;
        sum = '0;
        for (int i = 0; i < NE; i++) begin
            p = st_prod[LS][i];
            if (st_op[LS] == OP_SMAC) begin
                sum = sum + {{(RW-PW){p[PW-1]}}, p};
            end else begin
                sum = sum + {{(RW-PW){1'b0}}, p};
            end
        end
        cur = '0;
        for (int j = 0; j < N_ACC; j++) begin
            if (int'(st_idx[LS]) == j) begin
                cur = acc[j];
            end
        end
        unique case (st_op[LS])
            OP_CLR:  nxt = '0;
            OP_UMAC: nxt = cur + sum;
            OP_SMAC: nxt = cur + sum;
            default: nxt = cur;
        endcase
        upd_ok = st_vld[LS] & (st_eid[LS] == 2'd0);
    end

    // Accumulators change only as a legal entry leaves the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_ACC; j++) begin
                acc[j] <= '0;
            end
        end else if (!stall && upd_ok && st_op[LS] != OP_READ) begin
            for (int j = 0; j < N_ACC; j++) begin
                if (int'(st_idx[LS]) == j) begin
                    acc[j] <= nxt;
                end
            end
        end
    end

    // Output register holds the response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_err  <= 1'b0;
            out_eid  <= 2'd0;
            out_data <= '0;
        end else if (!stall) begin
            out_vld  <= st_vld[LS];
            out_err  <= st_vld[LS] & (st_eid[LS] != 2'd0);
            out_eid  <= st_vld[LS] ? st_eid[LS] : 2'd0;
            out_data <= upd_ok ? nxt : '0;
        end
    end

    // Hold off requests until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mulacc_simd_cfu_li2.sv
// Self-checking bench: randomized and directed traffic compared
// against a queue-based behavioural model of the CFU.
module tb_mulacc_simd_cfu_li2;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [4:0]  req_func_id = '0;
    logic [31:0] req_data0 = '0;
    logic [31:0] req_data1 = '0;
    logic        resp_ready = 1'b1;

    logic        req_ready, req_ready3;
    logic        resp_valid, resp_valid3;
    logic [31:0] resp_data, resp_data3;
    logic        resp_err, resp_err3;
    logic [31:0] resp_err_id, resp_err_id3;

    mulacc_simd_cfu_li2 #(.N_ACC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func_id(req_func_id),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .resp_err_id(resp_err_id)
    );

    mulacc_simd_cfu_li2 #(.N_ACC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready3),
        .req_func_id(req_func_id),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid3), .resp_ready(resp_ready),
        .resp_data(resp_data3), .resp_err(resp_err3),
        .resp_err_id(resp_err_id3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic [31:0] id;
        logic [31:0] d3;
        logic        e3;
        logic [31:0] id3;
        int          rem;
    } exp_t;

    req_t        rq[$];
    exp_t        infl[$];
    logic [31:0] got[$];
    logic [31:0] acc_m[4];
    bit          rdy_m = 1'b0;
    bit          gap_mode = 1'b0;
    bit          pend_release = 1'b0;
    int          rr_mode = 0;
    int          pc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int op, input int k,
                       input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.f = {k[1:0], op[2:0]};
        r.a = a;
        r.b = b;
        rq.push_back(r);
    endtask

    // Reference: sum of element products, then accumulator rules.
    task automatic apply(input req_t r);
        exp_t   e;
        int     op;
        int     k;
        longint s;
        byte    sa, sb;
        logic [7:0] ua, ub;
        op = int'(r.f[2:0]);
        k  = int'(r.f[4:3]);
        s  = 0;
        for (int i = 0; i < 4; i++) begin
            ua = r.a[i*8 +: 8];
            ub = r.b[i*8 +: 8];
            sa = ua;
            sb = ub;
            if (op == 2) s += longint'(sa) * longint'(sb);
            else         s += longint'(ua) * longint'(ub);
        end
        e.id  = (op > 3) ? 1 : 0;
        e.id3 = (op > 3) ? 1 : (k >= 3) ? 2 : 0;
        e.d   = 0;
        if (op <= 3) begin
            if (op == 0) acc_m[k] = 0;
            if (op == 1 || op == 2) acc_m[k] = acc_m[k] + s[31:0];
            e.d = acc_m[k];
        end
        e.e   = (e.id != 0);
        e.e3  = (e.id3 != 0);
        e.d3  = e.e3 ? 32'd0 : e.d;
        e.rem = L - 1;
        infl.push_back(e);
    endtask

    function automatic logic rr_fn();
        if (rr_mode == 0) return 1'b1;
        if (pc < 10) return 1'b1;
        if (pc < 15) return 1'b0;
        return (pc % 3) == 0;
    endfunction

    task automatic step();
        bit vis, stall, acc_now;
        @(negedge clk);
        if (pend_release) begin
            rst_n = 1'b1;
            pend_release = 1'b0;
        end
        resp_ready = rr_fn();
        req_valid = (rq.size() > 0) &&
                    (!gap_mode || $urandom_range(3) != 0);
        if (rq.size() > 0) begin
            req_func_id = rq[0].f;
            req_data0   = rq[0].a;
            req_data1   = rq[0].b;
        end else begin
            req_func_id = 5'($urandom);
            req_data0   = $urandom;
            req_data1   = $urandom;
        end
        #1;
        vis   = infl.size() > 0 && infl[0].rem == 0;
        stall = vis && !resp_ready;
        chk("req_ready", req_ready, rdy_m && !stall);
        chk("req_ready3", req_ready3, rdy_m && !stall);
        chk("resp_valid", resp_valid, vis);
        chk("resp_valid3", resp_valid3, vis);
        if (vis) begin
            chk("resp_data", resp_data, infl[0].d);
            chk("resp_err", resp_err, infl[0].e);
            chk("resp_err_id", resp_err_id, infl[0].id);
            chk("resp_data3", resp_data3, infl[0].d3);
            chk("resp_err3", resp_err3, infl[0].e3);
            chk("resp_err_id3", resp_err_id3, infl[0].id3);
            if (resp_ready) got.push_back(resp_data);
        end
        acc_now = req_valid && rdy_m && !stall;
        @(posedge clk);
        pc++;
        if (!stall) begin
            if (vis) void'(infl.pop_front());
            for (int i = 0; i < infl.size(); i++) begin
                if (infl[i].rem > 0) infl[i].rem = infl[i].rem - 1;
            end
        end
        if (acc_now) apply(rq.pop_front());
        rdy_m = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() > 0 || infl.size() > 0) && n < 3000) begin
            step();
            n++;
        end
        if (rq.size() > 0 || infl.size() > 0) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed %0d pending expected 0",
                   rq.size() + infl.size());
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_resp_err_id"}, resp_err_id, 0);
        chk({tag, "_req_ready3"}, req_ready3, 0);
        chk({tag, "_resp_valid3"}, resp_valid3, 0);
        chk({tag, "_resp_data3"}, resp_data3, 0);
    endtask

    initial begin
        logic [7:0]  kb;
        logic [31:0] a, b;
        for (int j = 0; j < 4; j++) acc_m[j] = 0;

        // Reset values before any clock edge.
        #1;
        chk_zero("reset");
        pend_release = 1'b1;

        // Gauss sum into acc0.
        put(0, 0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            kb = 8'(k);
            put(1, 0, 32'h01010101, {4{kb}});
        end
        put(3, 0, 0, 0);
        got.delete();
        drain();
        chk("gauss_count", got.size(), 102);
        if (got.size() == 102) begin
            chk("gauss_last", got[100], 20200);
            chk("gauss_read", got[101], 20200);
        end

        // Signed versus unsigned products.
        put(0, 1, 0, 0);
        put(0, 2, 0, 0);
        put(2, 1, 32'hFFFFFFFF, 32'h02020202);
        put(1, 2, 32'hFFFFFFFF, 32'h02020202);
        put(3, 0, 0, 0);
        got.delete();
        drain();
        chk("sign_count", got.size(), 5);
        if (got.size() == 5) begin
            chk("smac", got[2], 32'hFFFFFFF8);
            chk("umac", got[3], 2040);
            chk("acc0_kept", got[4], 20200);
        end

        // Interleaved accumulators with bubbles and wrap-around on acc3.
        gap_mode = 1'b1;
        put(0, 1, 0, 0);
        put(0, 3, 0, 0);
        put(2, 3, 32'h80808080, 32'h7F7F7F7F);
        for (int i = 0; i < 100; i++) begin
            put(1, (i % 2 == 0) ? 1 : 3, $urandom, $urandom);
        end
        put(3, 1, 0, 0);
        put(3, 3, 0, 0);
        drain();
        gap_mode = 1'b0;

        // Back-pressure while streaming.
        rr_mode = 1;
        pc = 0;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            put(1, 0, a, b);
        end
        got.delete();
        drain();
        chk("bp_count", got.size(), 20);
        rr_mode = 0;

        // Error responses, then read every accumulator.
        put(5, 0, $urandom, $urandom);
        put(1, 3, 32'h01010101, 32'h01010101);
        put(7, 3, $urandom, $urandom);
        for (int j = 0; j < 4; j++) put(3, j, 0, 0);
        drain();

        // Asynchronous reset with two requests in flight.
        for (int i = 0; i < 4; i++) put(1, 1, $urandom, $urandom);
        step();
        step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_zero("async_rst");
        infl.delete();
        rq.delete();
        for (int j = 0; j < 4; j++) acc_m[j] = 0;
        rdy_m = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        pend_release = 1'b1;
        for (int j = 0; j < 4; j++) put(3, j, 0, 0);
        got.delete();
        drain();
        chk("post_rst_count", got.size(), 4);
        for (int i = 0; i < 8; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mulacc_simd_cfu_li2.md
# mulacc_simd_cfu_li2

Level-2 (request/response handshaked) SIMD multiply-accumulate CFU with several independent accumulators and signed/unsigned modes. It extends the Level-1 pipelined dot-product unit in three ways:
- back-pressure via `req_ready` / `resp_ready`;
- accumulator selection encoded in the function ID;
- a read-without-modify operation and error responses for illegal functions.

It sits between a CPU CFU port and the rest of the design as a drop-in CFU_LI feature-level-2 unit.

## Interface
- CFU_FUNC_ID_W, 5, function ID width; `[2:0]` = opcode, `[CFU_FUNC_ID_W-1:3]` = accumulator index
- CFU_REQ_DATA_W, 32, request operand width; multiple of CFU_REQ_ELT_W
- CFU_REQ_ELT_W, 8, SIMD element width; N_ELTS = CFU_REQ_DATA_W/CFU_REQ_ELT_W
- CFU_RESP_DATA_W, 32, accumulator / response width
- CFU_ERR_ID_W, 32, error ID width
- CFU_RESP_LATENCY, 3, unstalled request-to-response latency; ≥3
- N_ACC, 4, number of accumulators; ≤ 2^(CFU_FUNC_ID_W-3)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit accepts request this cycle
- req_func_id  in  CFU_FUNC_ID_W  opcode + accumulator index
- req_data0, req_data1  in  CFU_REQ_DATA_W  packed SIMD operands
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response this cycle
- resp_data  out  CFU_RESP_DATA_W  result
- resp_err  out  1  illegal request
- resp_err_id  out  CFU_ERR_ID_W  1 = bad opcode, 2 = accumulator index ≥ N_ACC, else 0

## Operation
- **Transfer rules.** A request transfers when `req_valid & req_ready`. A response transfers when `resp_valid & resp_ready`.
- **Opcodes** (`func_id[2:0]`):
  - 0 CLEAR: acc[k] = 0; respond 0.
  - 1 UMAC: acc[k] += Σ unsigned products.
  - 2 SMAC: acc[k] += Σ signed (two's-complement) products.
  - 3 READ: respond acc[k]; acc[k] unchanged.
  - 4–7: error, err_id 1.
- **Index check.** Index k ≥ N_ACC gives error, err_id 2. The opcode error takes precedence.
- **Error responses.** Errors travel the pipeline with normal latency. resp_data = 0 and no accumulator changes.
- **Products.** Each element product is 2·CFU_REQ_ELT_W bits wide.
  - UMAC: products are zero-extended to CFU_RESP_DATA_W.
  - SMAC: products are sign-extended to CFU_RESP_DATA_W.
  - Products are summed, then added to acc[k]. All arithmetic wraps modulo 2^CFU_RESP_DATA_W; there is no saturation.
- **Pipeline.**
  - Stage 0 registers the per-element products, the opcode/index/error code, and valid.
  - Stages 1..L-2 delay these values.
  - On the edge that moves a valid entry from stage L-2 into the output register, the accumulator update is applied. The output register captures the post-update acc[k] (or 0 for CLEAR/error).
  - Requests update accumulators strictly in acceptance order, one per cycle. Back-to-back requests to the same accumulator therefore need no forwarding.
- **Stall.** stall = resp_valid & ~resp_ready.
  - While stall is high, every pipeline stage, the accumulators and the output register hold.
  - req_ready = ready_q & ~stall. ready_q is a flop cleared by reset and set on the first clk edge after rst_n rises.
  - No request is dropped or duplicated; response order equals request order.
- **Reset** (rst_n low, asynchronous):
  - Clears all valid bits, the accumulators, the output register and ready_q.
  - Output values while reset is held: req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0, resp_err_id = 0.
  - In-flight requests are discarded without response.

## Timing
- Unstalled: a request accepted on edge T gives resp_valid high after edge T+L-1, i.e. L cycles later, with L = CFU_RESP_LATENCY.
- Throughput: one request per cycle while resp_ready = 1.
- Each cycle of stall (resp_valid high with resp_ready low) delays all in-flight responses by exactly one cycle; req_ready is low in those cycles.
- Simultaneous acceptance and response on the same edge is permitted and required for full throughput.
- resp_valid may go low between responses (bubbles) when req_valid was low; bubbles advance freely and never stall.
- READ immediately after MAC to the same accumulator returns the post-MAC value.

## Test plan
- **Gauss sum.** Reset, then CLEAR acc0. Then 100 UMACs with data0 = {4{8'd1}} and data1 = {4{k}} for k = 1..100, back-to-back.
  - Each response equals 4·Σ(1..k).
  - The last response is 20200.
  - READ acc0 returns 20200.
- **Signed vs unsigned.** data0 = 0xFFFFFFFF, data1 = 0x02020202.
  - SMAC into cleared acc1 → 0xFFFFFFF8.
  - UMAC into cleared acc2 → 2040.
  - acc0 is unchanged.
- **Interleaved accumulators.** Alternate UMAC to acc1 and acc3, 50 each, using random operands.
  - Every response matches the per-accumulator reference model.
  - Each accumulator is independent.
  - Wrap-around past 2^32 matches the model modulo 2^32.
- **Back-pressure.** While streaming 20 UMACs, drop resp_ready for 5 cycles at response 7, then pulse it 1-of-3.
  - req_ready goes low exactly in stall cycles.
  - All 20 responses arrive, in order, with correct values.
  - There are no duplicates.
- **Errors.** Opcode 5 → resp_err = 1, err_id = 1, data 0. Index 3 with N_ACC = 3 → err_id 2.
  - A subsequent READ shows all accumulators unchanged.
  - Error latency equals L.
- **Async reset mid-stream.** Assert rst_n low between clock edges with 2 requests in flight.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, req_ready rises after one edge.
  - READ of every accumulator returns 0.
  - No stale responses appear.
